// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-configurable Moore serial pattern detector with saturating match counter
//   clock        : system clock, rising edge
//   reset        : asynchronous active-high; restores the 1011 overlapping detector
//   enable       : sample sequence_in this cycle
//   sequence_in  : serial data bit
//   cfg_load     : strobe latching cfg_pattern / cfg_len / cfg_overlap
//   cfg_pattern  : pattern, bit [cfg_len-1] received first, bit [0] last
//   cfg_len      : pattern length, legal 1..MAX_LEN
//   cfg_overlap  : 1 = overlapping matches, 0 = history flushed after a match
//   count_clr    : synchronous clear of match_count
//   detector_out : registered match flag
//   match_count  : saturating match count
//   cfg_err      : one-cycle pulse after a rejected cfg_load
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 8,
    parameter int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               sequence_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               detector_out,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);
    logic [MAX_LEN-1:0] pat_r, hist, hist_n, mask;
    logic [LEN_W-1:0]   len_r, fill, fill_n;
    logic               ovl_r, match, cfg_ok;
    logic [CNT_W-1:0]   count_n;
    always_comb begin
        hist_n  = {hist[MAX_LEN-2:0], sequence_in};
        fill_n  = (fill >= len_r) ? len_r : fill + LEN_W'(1);
        // shifting by len_r == MAX_LEN yields zero, so the mask becomes all ones
        mask    = ~({MAX_LEN{1'b1}} << len_r);
        match   = enable && !cfg_load && (fill_n == len_r) && (((hist_n ^ pat_r) & mask) == '0);
        cfg_ok  = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        count_n = count_clr ? CNT_W'(match)
                : (match && !(&match_count)) ? match_count + CNT_W'(1)
                : match_count;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_r        <= MAX_LEN'(4'b1011);
            len_r        <= LEN_W'(4);
            ovl_r        <= 1'b1;
            hist         <= '0;
            fill         <= '0;
            detector_out <= 1'b0;
            match_count  <= '0;
            cfg_err      <= 1'b0;
        end else begin
            cfg_err     <= cfg_load && !cfg_ok;
            match_count <= count_n;
            if (cfg_load) begin
                if (cfg_ok) begin
                    pat_r        <= cfg_pattern;
                    len_r        <= cfg_len;
                    ovl_r        <= cfg_overlap;
                    hist         <= '0;
                    fill         <= '0;
                    detector_out <= 1'b0;
                end
            end else if (enable) begin
                detector_out <= match;
                hist         <= (match && !ovl_r) ? '0 : hist_n;
                fill         <= (match && !ovl_r) ? '0 : fill_n;
            end
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench; a second instance with a 2-bit counter shares all inputs
module tb_seq_detector_param;
    localparam int ML = 8;
    logic          clock = 1'b0, reset = 1'b1, enable = 1'b0, sequence_in = 1'b0;
    logic          cfg_load = 1'b0, cfg_overlap = 1'b0, count_clr = 1'b0;
    logic [ML-1:0] cfg_pattern = '0;
    logic [3:0]    cfg_len = '0;
    logic          det, err, det2, err2;
    logic [7:0]    cnt;
    logic [1:0]    cnt2;
    int            checks = 0, failures = 0;

    seq_detector_param #(.MAX_LEN(ML), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .detector_out(det), .match_count(cnt), .cfg_err(err)
    );
    seq_detector_param #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .sequence_in(sequence_in),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .count_clr(count_clr),
        .detector_out(det2), .match_count(cnt2), .cfg_err(err2)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cfg_load = 1'b0;
        count_clr = 1'b0;
    endtask

    task automatic idle(input logic exp_det, input string tag);
        enable = 1'b0;
        sequence_in = 1'b1;
        tick();
        chk(tag, 32'({det2, det}), 32'({exp_det, exp_det}));
    endtask

    task automatic bit_in(input logic b, input logic exp_det, input string tag);
        enable = 1'b1;
        sequence_in = b;
        tick();
        chk(tag, 32'({det2, det}), 32'({exp_det, exp_det}));
    endtask

    task automatic stream(input logic [7:0] bits, input logic [7:0] exp, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic clr);
        cfg_load = 1'b1;
        cfg_pattern = pat;
        cfg_len = len;
        cfg_overlap = ovl;
        count_clr = clr;
        enable = 1'b1;
        sequence_in = 1'b1;
        tick();
    endtask

    initial begin
        #12 reset = 1'b0;
        chk("reset_det", 32'({det2, det}), 32'(0));
        chk("reset_cnt", 32'({cnt2, cnt}), 32'(0));
        chk("reset_err", 32'({err2, err}), 32'(0));
        stream(8'b1011011, 8'b0001001, 7, "dflt");
        chk("dflt_cnt", 32'(cnt), 32'(2));
        chk("dflt_cnt2", 32'(cnt2), 32'(2));

        load(8'b1011, 4'd4, 1'b0, 1'b1);
        chk("noovl_load_det", 32'({det2, det}), 32'(0));
        chk("noovl_load_err", 32'({err2, err}), 32'(0));
        chk("noovl_load_cnt", 32'(cnt), 32'(0));
        stream(8'b1011011, 8'b0001000, 7, "noovl");
        chk("noovl_cnt", 32'(cnt), 32'(1));

        load(8'b1010_0111, 4'd3, 1'b1, 1'b1);
        stream(8'b11111, 8'b00111, 5, "ones");
        chk("ones_cnt", 32'(cnt), 32'(3));
        chk("ones_cnt2", 32'(cnt2), 32'(3));

        load(8'b1011, 4'd4, 1'b1, 1'b1);
        stream(8'b101, 8'b000, 3, "en");
        idle(1'b0, "en_gap1");
        idle(1'b0, "en_gap2");
        bit_in(1'b1, 1'b1, "en_hit");
        idle(1'b1, "en_hold1");
        idle(1'b1, "en_hold2");
        bit_in(1'b0, 1'b0, "en_drop");
        chk("en_cnt", 32'(cnt), 32'(1));

        load(8'hFF, 4'd0, 1'b0, 1'b0);
        chk("err_len0", 32'({err2, err}), 32'(3));
        idle(1'b0, "err_len0_idle");
        chk("err_len0_clr", 32'({err2, err}), 32'(0));
        load(8'hFF, 4'd9, 1'b0, 1'b0);
        chk("err_len9", 32'({err2, err}), 32'(3));
        idle(1'b0, "err_len9_idle");
        chk("err_len9_clr", 32'({err2, err}), 32'(0));
        bit_in(1'b1, 1'b0, "err_keep_b1");
        bit_in(1'b1, 1'b1, "err_keep_b2");
        chk("err_keep_cnt", 32'(cnt), 32'(2));

        load(8'b1011, 4'd4, 1'b1, 1'b1);
        stream(8'b101, 8'b000, 3, "mid");
        load(8'b1011, 4'd4, 1'b1, 1'b0);
        stream(8'b1011, 8'b0001, 4, "mid_after");

        load(8'h01, 4'd1, 1'b0, 1'b1);
        stream(8'b11111, 8'b11111, 5, "len1");
        chk("sat_cnt", 32'(cnt), 32'(5));
        chk("sat_cnt2", 32'(cnt2), 32'(3));
        count_clr = 1'b1;
        bit_in(1'b1, 1'b1, "clr_hit");
        chk("clr_match_cnt", 32'({cnt2, cnt}), 32'({2'd1, 8'd1}));
        count_clr = 1'b1;
        idle(1'b1, "clr_only");
        chk("clr_only_cnt", 32'({cnt2, cnt}), 32'(0));

        load(8'b1100_1010, 4'd8, 1'b1, 1'b1);
        stream(8'b1100_1010, 8'b0000_0001, 8, "len8");
        chk("len8_cnt", 32'(cnt), 32'(1));

        #3 reset = 1'b1;
        #1;
        chk("async_det", 32'({det2, det}), 32'(0));
        chk("async_cnt", 32'({cnt2, cnt}), 32'(0));
        #2 reset = 1'b0;
        stream(8'b1011, 8'b0001, 4, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised Moore-style serial pattern detector; next generation of the team's fixed 1011 detector. Pattern, length and overlap mode are runtime-loadable. Adds an enable qualifier and a saturating match counter. Sits on the same single-bit serial input path. Reset defaults reproduce the fixed 1011 overlapping detector exactly.

Parameters:
MAX_LEN, 8, maximum pattern length in bits; legal range 4..32.
CNT_W, 8, width of match_count.
LEN_W, $clog2(MAX_LEN+1), width of cfg_len; derived, do not override.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high.
enable  input  1  sample sequence_in this cycle when high.
sequence_in  input  1  serial data bit.
cfg_load  input  1  one-cycle strobe; latch cfg_pattern, cfg_len and cfg_overlap.
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received, bit [0] is the last.
cfg_len  input  LEN_W  pattern length.
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history flushed after a match.
count_clr  input  1  synchronous clear of match_count.
detector_out  output  1  registered Moore match flag.
match_count  output  CNT_W  saturating count of matches.
cfg_err  output  1  one-cycle pulse when a cfg_load is rejected.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clock.
- Reset values:
  - pat_r = 1011 (zero-extended); len_r = 4; ovl_r = 1.
  - Shift history = 0; fill count = 0.
  - detector_out = 0; match_count = 0; cfg_err = 0.
- Internal state:
  - hist: MAX_LEN-bit shift register; new bit enters at bit 0.
  - fill: LEN_W-bit count, saturating at len_r.
- Priority each edge: reset > cfg_load > enable sampling.
- cfg_load = 1:
  - If 1 <= cfg_len <= MAX_LEN: latch all three config fields, clear hist, fill and detector_out.
  - Otherwise: config is unchanged, hist and fill are unchanged, and cfg_err = 1 for the next cycle.
  - sequence_in is discarded in this cycle regardless of enable.
  - match_count is unaffected.
- enable = 1 (and no cfg_load):
  - hist_n = {hist[MAX_LEN-2:0], sequence_in}.
  - fill_n = min(fill+1, len_r).
  - match = (fill_n == len_r) and (hist_n[len_r-1:0] == pat_r[len_r-1:0]).
  - detector_out <= match.
  - On match with ovl_r = 0: hist and fill are cleared instead of taking hist_n/fill_n.
  - On match with ovl_r = 1: hist_n and fill_n are kept.
- enable = 0: hist, fill and detector_out hold their values. A high detector_out therefore stays high until the next enabled sample.
- Latency: detector_out rises in the cycle after the edge that samples the final pattern bit. This is Moore timing, identical to the fixed detector.
- Back-to-back: in overlap mode, a pattern that overlaps itself gives consecutive or closely spaced detector_out pulses with no gap cycles forced.
- match_count:
  - Increments by 1 on each edge where match = 1; saturates at 2^CNT_W-1 with no wrap.
  - count_clr alone: next value is 0.
  - count_clr together with match: next value is 1.
- Length 1: every enabled bit equal to pat_r[0] is a match. In non-overlap mode fill returns to 0, so consecutive matches are still possible.
- Pattern bits above len_r-1 are ignored.
- Reset mid-stream: all state, including config, returns to the reset defaults asynchronously.

Test Plan:
- Defaults after reset, enable = 1, stream 1,0,1,1,0,1,1 -> detector_out high in the cycles after bits 4 and 7 only; match_count = 2.
- cfg_load with pattern 1011, len 4, overlap 0, then the same stream -> single pulse after bit 4; match_count = 1.
- cfg_load with len 3, pattern 111, overlap 1, stream 1,1,1,1,1 -> pulses after bits 3, 4 and 5; match_count = 3.
- Stream 1,0,1 with enable = 0 for 2 cycles, then 1 -> pulse appears only after the enabled 4th bit. A pulse with enable then dropped holds detector_out = 1.
- cfg_load with len 0, then len MAX_LEN+1 -> cfg_err pulses each time; the 1011 config still detects afterwards. cfg_load mid-pattern (after 1,0,1) followed by 1 -> no match, because history was cleared.
- CNT_W = 2: drive 5 matches -> match_count sticks at 3. count_clr coincident with a match -> 1. Reset asserted mid-pattern -> outputs 0 immediately, without waiting for a clock edge.
